// File: rtl/apb_pkg.sv
// Shared types and widths for the APB requester.
package apb_pkg;
   localparam int APB_ADDR_W = 10;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_mst_state_t;
endpackage

// File: rtl/apb_wait_ctr.sv
// ACCESS-phase wait counter; flags the last permitted cycle before abort.
module apb_wait_ctr #(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic TIMEOUT_ON = (TIMEOUT != 0);

   logic [CW-1:0] cnt_reg;

   // Holds at LAST instead of wrapping, so an idle expired flag stays asserted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_reg <= '0;
      else if (clr_i)
         cnt_reg <= '0;
      else if (en_i && !expired_o)
         cnt_reg <= cnt_reg + CW'(1);
   end

   assign expired_o = TIMEOUT_ON && (cnt_reg == LAST);
endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: command port in, SETUP/ACCESS sequencing, response port out.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic              pwrite_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i
);
   apb_mst_state_t state_reg, state_next;

   logic              write_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              err_reg;
   logic              expired;

   apb_wait_ctr #(.TIMEOUT(TIMEOUT)) u_wait_ctr (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (state_reg == IDLE),
      .en_i      ((state_reg == ACCESS) && !pready_i),
      .expired_o (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cmd_valid_i)           state_next = SETUP;
         SETUP:                              state_next = ACCESS;
         ACCESS:  if (pready_i || expired)   state_next = RESP;
         RESP:    if (rsp_ready_i)           state_next = IDLE;
         default:                            state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = (state_reg == IDLE);
      psel_o      = (state_reg == SETUP) || (state_reg == ACCESS);
      penable_o   = (state_reg == ACCESS);
      rsp_valid_o = (state_reg == RESP);
   end

   // Write data is masked at accept so pwdata_o reads back 0 for read commands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_reg <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         if (state_reg == IDLE && cmd_valid_i) begin
            write_reg <= cmd_write_i;
            addr_reg  <= cmd_addr_i;
            wdata_reg <= cmd_write_i ? cmd_wdata_i : '0;
         end
         if (state_reg == ACCESS) begin
            if (pready_i) begin
               rdata_reg <= write_reg ? '0 : prdata_i;
               err_reg   <= 1'b0;
            end else if (expired) begin
               rdata_reg <= '0;
               err_reg   <= 1'b1;
            end
         end
      end
   end

   assign paddr_o     = addr_reg;
   assign pwrite_o    = write_reg;
   assign pwdata_o    = wdata_reg;
   assign rsp_rdata_o = rdata_reg;
   assign rsp_err_o   = err_reg;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a simple wait-programmable APB memory slave.
module tb_apb_master;
   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [9:0]  cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        psel_o, penable_o, pwrite_o, pready_i;
   logic [9:0]  paddr_o;
   logic [31:0] pwdata_o, prdata_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .paddr_o     (paddr_o),
      .pwrite_o    (pwrite_o),
      .pwdata_o    (pwdata_o),
      .prdata_i    (prdata_i),
      .pready_i    (pready_i)
   );

   // Slave: asserts pready after wait_n non-ready ACCESS cycles.
   bit [31:0] mem [1024];
   int        acc_cnt = 0;
   int        wait_n  = 0;

   always_comb begin
      pready_i = psel_o && penable_o && (acc_cnt == wait_n);
      prdata_i = mem[paddr_o];
   end

   always @(posedge clk) begin
      if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
      else                                  acc_cnt <= 0;
      if (psel_o && penable_o && pready_i && pwrite_o) mem[paddr_o] <= pwdata_o;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        write;
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          wait_n;
      int          bp;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   task automatic do_txn(input vec_t v, input int n);
      int g, lat, bp_bad;
      logic bad;
      wait_n = v.wait_n;
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_write_i = v.write;
      cmd_addr_i  = v.addr;
      cmd_wdata_i = v.wdata;
      g = 0;
      while (!cmd_ready_o && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!cmd_ready_o) begin
         check("cmd_ready_timeout", 0, 1);
         cmd_valid_i = 1'b0;
         return;
      end
      @(negedge clk);
      cmd_valid_i = 1'b0;
      cmd_wdata_i = 32'h5555_5555;
      cmd_addr_i  = 10'h3FF;
      lat = 1;
      bad = 1'b0;
      while (!rsp_valid_o && lat < 100) begin
         if (lat == 1 && !(psel_o && !penable_o)) bad = 1'b1;
         if (lat >= 2 && !(psel_o && penable_o))  bad = 1'b1;
         if (cmd_ready_o)                         bad = 1'b1;
         if (paddr_o !== v.addr || pwrite_o !== v.write) bad = 1'b1;
         if (pwdata_o !== (v.write ? v.wdata : 32'h0))   bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      check("phase_seq", {63'h0, bad}, 64'h0);
      check("latency", 64'(lat), 64'(v.exp_lat));
      check("rsp_rdata", {32'h0, rsp_rdata_o}, {32'h0, v.exp_rdata});
      check("rsp_err", {63'h0, rsp_err_o}, {63'h0, v.exp_err});
      check("resp_bus_idle", {61'h0, psel_o, penable_o, cmd_ready_o}, 64'h0);
      check("paddr_retained", {54'h0, paddr_o}, {54'h0, v.addr});
      bp_bad = 0;
      for (int i = 0; i < v.bp; i++) begin
         rsp_ready_i = 1'b0;
         @(negedge clk);
         if (!rsp_valid_o || cmd_ready_o || rsp_rdata_o !== v.exp_rdata || rsp_err_o !== v.exp_err)
            bp_bad++;
      end
      if (v.bp > 0) check("backpressure_stable", 64'(bp_bad), 64'h0);
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check("post_handshake", {62'h0, cmd_ready_o, rsp_valid_o}, 64'h2);
      $display("txn %0d: %s addr=0x%03h rdata=0x%08h err=%0d latency=%0d",
               n, v.write ? "WR" : "RD", v.addr, v.exp_rdata, v.exp_err, lat);
   endtask

   vec_t vecs [13];

   initial begin
      int idx, rcnt, outst, maxo, g, post_rsp;
      logic acc;

      vecs[0]  = '{1'b1, 10'h003, 32'hDEADBEEF, 3,   0,  32'h0,        1'b0, 6};
      vecs[1]  = '{1'b0, 10'h003, 32'h0,        3,   0,  32'hDEADBEEF, 1'b0, 6};
      vecs[2]  = '{1'b1, 10'h00A, 32'h12345678, 0,   0,  32'h0,        1'b0, 3};
      vecs[3]  = '{1'b0, 10'h00A, 32'h0,        0,   10, 32'h12345678, 1'b0, 3};
      vecs[4]  = '{1'b0, 10'h00A, 32'h0,        255, 0,  32'h0,        1'b1, 34};
      vecs[5]  = '{1'b0, 10'h00A, 32'h0,        31,  0,  32'h12345678, 1'b0, 34};
      vecs[6]  = '{1'b0, 10'h00A, 32'h0,        30,  0,  32'h12345678, 1'b0, 33};
      vecs[7]  = '{1'b1, 10'h005, 32'hCAFEF00D, 255, 0,  32'h0,        1'b1, 34};
      vecs[8]  = '{1'b0, 10'h005, 32'h0,        1,   0,  32'h0,        1'b0, 4};
      vecs[9]  = '{1'b1, 10'h000, 32'h000000A0, 1,   0,  32'h0,        1'b0, 4};
      vecs[10] = '{1'b1, 10'h001, 32'h000000A1, 2,   0,  32'h0,        1'b0, 5};
      vecs[11] = '{1'b1, 10'h002, 32'h000000A2, 0,   0,  32'h0,        1'b0, 3};
      vecs[12] = '{1'b1, 10'h003, 32'h000000A3, 1,   0,  32'h0,        1'b0, 4};

      reset       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_wdata_i = '0;
      rsp_ready_i = 1'b0;
      #1;
      check("reset_ctrl", {58'h0, psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, cmd_ready_o}, 64'h1);
      check("reset_data", {paddr_o, pwdata_o ^ rsp_rdata_o}, 64'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) do_txn(vecs[i], i);

      // Asynchronous reset while the slave is stalling in ACCESS.
      wait_n = 255;
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_write_i = 1'b1;
      cmd_addr_i  = 10'h00A;
      cmd_wdata_i = 32'h0BAD_0BAD;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      g = 0;
      while (!penable_o && g < 10) begin
         @(negedge clk);
         g++;
      end
      check("reached_access", {63'h0, penable_o}, 64'h1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_ctrl", {58'h0, psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, cmd_ready_o}, 64'h1);
      check("async_reset_data", {paddr_o, pwdata_o}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      post_rsp = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid_o || !cmd_ready_o) post_rsp++;
      end
      check("no_rsp_after_reset", 64'(post_rsp), 64'h0);
      $display("txn reset: abort mid-ACCESS, idle cycles checked=40");

      // Back-to-back reads with cmd_valid held and rsp_ready held.
      wait_n = 1;
      cmd_valid_i = 1'b1;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 10'h000;
      rsp_ready_i = 1'b1;
      idx = 0; rcnt = 0; outst = 0; maxo = 0; acc = 1'b0;
      for (int c = 0; c < 200 && rcnt < 4; c++) begin
         if (acc) begin
            idx++;
            acc = 1'b0;
            if (idx == 4) cmd_valid_i = 1'b0;
            else          cmd_addr_i  = 10'(idx);
         end
         if (cmd_valid_i && cmd_ready_o) begin
            acc = 1'b1;
            outst++;
         end
         if (rsp_valid_o) begin
            check("b2b_rdata", {32'h0, rsp_rdata_o}, 64'(32'hA0 + rcnt));
            $display("txn b2b %0d: RD rdata=0x%08h err=%0d", rcnt, rsp_rdata_o, rsp_err_o);
            rcnt++;
            outst--;
         end
         if (outst > maxo) maxo = outst;
         @(negedge clk);
      end
      cmd_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      check("b2b_count", 64'(rcnt), 64'h4);
      check("b2b_outstanding", 64'(maxo), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB requester that drives the APB memory slave interface.
- Accepts simple commands on a valid/ready port and sequences the APB SETUP and ACCESS phases.
- Waits for pready, then returns read data or write completion on a valid/ready response port.
- A programmable wait-timeout aborts transfers when the slave never answers.

Parameters:
- ADDR_W, 10, APB address width (matches slave paddr).
- DATA_W, 32, APB data width.
- TIMEOUT, 32, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  block can accept a command
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  command address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer takes the response
- rsp_rdata_o  out  DATA_W  read data (0 for writes and errors)
- rsp_err_o  out  1  1 = transfer timed out
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- pready_i  in  1  APB ready

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- Reset values: state IDLE; every output 0 except cmd_ready_o = 1. Command, response and wait-counter registers are cleared.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, latch write/addr/wdata and go to SETUP.
  - Clear the wait counter.
- SETUP:
  - psel_o = 1, penable_o = 0.
  - Exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - If pready_i: capture prdata_i into rsp_rdata when the command is a read, else capture 0. Set err = 0 and go to RESP.
  - Else if TIMEOUT != 0 and wait counter == TIMEOUT-1: set rdata = 0, err = 1, go to RESP.
  - Else increment the wait counter.
  - pready_i wins over timeout in the same cycle.
- RESP:
  - rsp_valid_o = 1; psel_o = penable_o = 0.
  - Hold rsp_rdata_o and rsp_err_o stable until rsp_valid_o & rsp_ready_i, then go to IDLE.
  - rsp_ready_i outside RESP is ignored.
- Address and data outputs:
  - paddr_o, pwrite_o and pwdata_o come directly from the latched command registers.
  - They are stable from SETUP through the ACCESS completion cycle and retain their last value in IDLE and RESP.
  - pwdata_o = 0 for reads.
- psel_o and penable_o are registered-state decodes: glitch-free and never high in IDLE or RESP.
  - The slave therefore sees psel & penable drop the cycle after pready. No back-to-back re-trigger of the slave FSM.
- Handshakes:
  - cmd_ready_o = 0 in SETUP, ACCESS and RESP, so only one transfer is outstanding.
  - A command can be accepted in the IDLE cycle immediately after the RESP handshake.
- Latency:
  - Accept at cycle T; SETUP at T+1; ACCESS starts at T+2.
  - pready seen at T+2+N gives rsp_valid_o at T+3+N.
  - Minimum accept-to-response latency is 3 cycles.
- Wait counter: width $clog2(TIMEOUT+1), minimum 1 bit. It never wraps and saturates conceptually at TIMEOUT-1.
- Reset mid-transfer: immediate return to IDLE with outputs at reset values. The pending response is discarded and no rsp_valid_o is issued.
- pready_i sampled in IDLE, SETUP or RESP is ignored.

Decomposition:
- Package apb_pkg:
  - apb_mst_state_t enum (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3).
  - APB_ADDR_W = 10 and APB_DATA_W = 32 constants.
- Sub-module apb_wait_ctr: parameter TIMEOUT; inputs clk, reset, clr_i, en_i; output expired_o. It holds the ACCESS-phase wait counter.
- FSM and datapath registers stay in apb_master.

Test Plan:
1. Write then read, slave pready after 4 ACCESS cycles:
   - Write addr 0x003, data 0xDEADBEEF → psel high 1 cycle before penable; paddr/pwdata stable. Response rsp_valid with err = 0, rdata = 0.
   - Read addr 0x003 → rsp_rdata_o = 0xDEADBEEF.
2. Zero-wait slave (pready high on first ACCESS cycle): cmd accepted at T → rsp_valid_o at T+3. psel/penable low at T+4.
3. Response back-pressure: hold rsp_ready_i = 0 for 10 cycles → rsp_valid_o, rdata and err stable, cmd_ready_o = 0 throughout. Release → cmd_ready_o = 1 next cycle.
4. Timeout with TIMEOUT = 32 and pready_i tied 0:
   - Read addr 0x00A → exactly 32 ACCESS cycles, then rsp_err_o = 1, rsp_rdata_o = 0.
   - Repeat with pready asserted on the 32nd cycle → err = 0, data captured.
5. Reset asserted asynchronously during ACCESS → all outputs 0 and cmd_ready_o = 1 with no clock edge needed. No response after reset release.
6. Back-to-back commands with cmd_valid_i held high for 4 reads (addr 0–3) against the day-18 slave → 4 responses in order with matching data, and never more than one outstanding.
